// File: rtl/cmd_uart_rcv.sv
// 8N1 serial command receiver: oversampled by a baud counter, holds each framed byte
// in cmd with a cmd_rdy / clr_cmd_rdy handshake toward the command & control block.
module cmd_uart_rcv #(
  parameter int BAUD_DIV = 2604,
  parameter int CNT_W    = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_cmd_rdy,
  output logic [7:0] cmd,
  output logic       cmd_rdy,
  output logic       frm_err,
  output logic       ovr
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] RECV  = 3'd2;
  localparam logic [2:0] STOP  = 3'd3;
  localparam logic [2:0] BRK   = 3'd4;

  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BAUD_DIV - 1);

  logic             rx_meta;
  logic             rx_s;
  logic             rx_prev;
  logic [2:0]       state;
  logic [2:0]       state_next;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shift;
  logic             load_pend;
  logic             rx_fall;
  logic             half_hit;
  logic             full_hit;
  logic             bit_sample;
  logic             stop_sample;

  // Synchronizer and edge-detect flops preset to idle-high so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= RX;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  assign rx_fall     = rx_prev & ~rx_s;
  assign half_hit    = (baud_cnt == HALF_CNT);
  assign full_hit    = (baud_cnt == FULL_CNT);
  assign bit_sample  = (state == RECV) && full_hit;
  assign stop_sample = (state == STOP) && full_hit;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rx_fall) state_next = START;
      START:   if (half_hit) state_next = rx_s ? IDLE : RECV;
      RECV:    if (full_hit && (bit_cnt == 3'd7)) state_next = STOP;
      STOP:    if (full_hit) state_next = rx_s ? IDLE : BRK;
      BRK:     if (rx_s) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Counter restarts at every transition and after each data sample; parked at zero while waiting for the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
    end else if ((state_next != state) || bit_sample || (state == IDLE) || (state == BRK)) begin
      baud_cnt <= '0;
    end else begin
      baud_cnt <= baud_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt <= 3'd0;
      shift   <= 8'h00;
    end else if ((state == START) && (state_next == RECV)) begin
      bit_cnt <= 3'd0;
    end else if (bit_sample) begin
      bit_cnt <= bit_cnt + 3'd1;
      shift   <= {rx_s, shift[7:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_pend <= 1'b0;
      frm_err   <= 1'b0;
    end else begin
      load_pend <= stop_sample & rx_s;
      frm_err   <= stop_sample & ~rx_s;
    end
  end

  // A load beats a concurrent clear, and only an unconsumed byte that is not being cleared counts as overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd     <= 8'h00;
      cmd_rdy <= 1'b0;
      ovr     <= 1'b0;
    end else if (load_pend) begin
      cmd     <= shift;
      cmd_rdy <= 1'b1;
      ovr     <= cmd_rdy & ~clr_cmd_rdy;
    end else begin
      ovr <= 1'b0;
      if (clr_cmd_rdy) begin
        cmd_rdy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cmd_uart_rcv.sv
// Bench for cmd_uart_rcv: a frame-level model predicts outputs cycle by cycle for a
// BAUD_DIV=16 instance; a BAUD_DIV=2604 instance receives skewed-baud frames.
module tb_cmd_uart_rcv;
  localparam int D  = 16;
  localparam int SD = 2604;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       clr;
  logic [7:0] cmd;
  logic       cmd_rdy;
  logic       frm_err;
  logic       ovr;
  logic       rx_slow;
  logic       clr_slow;
  logic [7:0] cmd_s;
  logic       cmd_rdy_s;
  logic       frm_err_s;
  logic       ovr_s;

  always #5 clk = ~clk;

  cmd_uart_rcv #(.BAUD_DIV(D), .CNT_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .RX(rx), .clr_cmd_rdy(clr),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .frm_err(frm_err), .ovr(ovr)
  );

  cmd_uart_rcv #(.BAUD_DIV(SD), .CNT_W(12)) dut_slow (
    .clk(clk), .rst_n(rst_n), .RX(rx_slow), .clr_cmd_rdy(clr_slow),
    .cmd(cmd_s), .cmd_rdy(cmd_rdy_s), .frm_err(frm_err_s), .ovr(ovr_s)
  );

  typedef struct {
    int         edge_c;
    bit         is_load;
    logic [7:0] data;
  } ev_t;

  ev_t  evq[$];
  int   cyc = 0;
  int   n_total = 0;
  int   n_pass = 0;
  int   fast_rise = -1;
  int   fast_frm = -1;
  int   ovr_cnt = 0;
  int   slow_rise = -1;
  bit   slow_bad = 1'b0;

  logic [7:0] m_cmd;
  logic       m_rdy;
  logic       m_frm;
  logic       m_ovr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
  endtask

  // Frame-level model: each complete frame schedules a load or a framing error at the edge
  // given by the receiver latency; clears and overrun follow the handshake rules.
  initial begin
    ev_t        ev;
    bit         ld;
    logic [7:0] ld_data;
    logic       prev_rdy;
    logic       prev_rdy_s;
    m_cmd = 8'h00; m_rdy = 1'b0; m_frm = 1'b0; m_ovr = 1'b0;
    prev_rdy = 1'b0; prev_rdy_s = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      m_frm = 1'b0;
      m_ovr = 1'b0;
      if (!rst_n) begin
        m_cmd = 8'h00;
        m_rdy = 1'b0;
        evq.delete();
      end else begin
        ld = 1'b0;
        ld_data = 8'h00;
        while (evq.size() > 0 && evq[0].edge_c <= cyc) begin
          ev = evq.pop_front();
          if (ev.edge_c == cyc) begin
            if (ev.is_load) begin
              ld = 1'b1;
              ld_data = ev.data;
            end else begin
              m_frm = 1'b1;
            end
          end
        end
        if (ld) begin
          m_ovr = m_rdy && !clr;
          m_cmd = ld_data;
          m_rdy = 1'b1;
        end else if (clr) begin
          m_rdy = 1'b0;
        end
      end
      #2;
      chk("outputs{cmd,rdy,frm,ovr}", 32'({cmd, cmd_rdy, frm_err, ovr}),
          32'({m_cmd, m_rdy, m_frm, m_ovr}));
      if (cmd_rdy && !prev_rdy) fast_rise = cyc;
      prev_rdy = cmd_rdy;
      if (frm_err) fast_frm = cyc;
      if (ovr) ovr_cnt++;
      if (cmd_rdy_s && !prev_rdy_s) slow_rise = cyc;
      prev_rdy_s = cmd_rdy_s;
      if (frm_err_s || ovr_s) slow_bad = 1'b1;
    end
  end

  // Drives nbits of a frame, one bitlen-cycle slot per bit; s is the edge where the first synchronizer flop sees the start bit.
  task automatic send_frame(input bit slow, input logic [7:0] data, input int bitlen,
                            input bit stop_bit, input int nbits, input bit clr_at_load,
                            output int s);
    logic [9:0] frame;
    int         ld_edge;
    frame = {stop_bit, data, 1'b0};
    s = 0;
    ld_edge = 0;
    for (int c = 0; c < nbits * bitlen; c++) begin
      @(negedge clk);
      if (c == 0) begin
        s = cyc + 1;
        ld_edge = s + 3 + D / 2 + 9 * D;
        if (!slow && nbits == 10)
          evq.push_back('{edge_c: (stop_bit ? ld_edge : ld_edge - 1), is_load: stop_bit, data: data});
      end
      if (slow) rx_slow = frame[c / bitlen];
      else begin
        rx  = frame[c / bitlen];
        clr = clr_at_load && (cyc + 1 == ld_edge);
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clr();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    int s;
    rst_n = 1'b0; rx = 1'b1; rx_slow = 1'b1; clr = 1'b0; clr_slow = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_cmd", 32'(cmd), 32'h00);
    chk("reset_rdy", 32'(cmd_rdy), 32'h0);
    chk("reset_frm_ovr", 32'({frm_err, ovr}), 32'h0);
    rst_n = 1'b1;
    idle(5);

    // 0xA5: cmd_rdy rises at s + 3 + 8 + 9*16 = s + 155
    send_frame(1'b0, 8'hA5, D, 1'b1, 10, 1'b0, s);
    idle(2);
    chk("s1_cmd", 32'(cmd), 32'hA5);
    chk("s1_rdy", 32'(cmd_rdy), 32'h1);
    chk("s1_latency", 32'(fast_rise), 32'(s + 155));
    pulse_clr();
    chk("s1_clr_rdy", 32'(cmd_rdy), 32'h0);
    chk("s1_cmd_hold", 32'(cmd), 32'hA5);
    $display("txn s1: sent A5, cmd=%h rdy_rise=%0d", cmd, fast_rise);

    // 4-clock glitch must be rejected at the start sample
    repeat (4) begin @(negedge clk); rx = 1'b0; end
    @(negedge clk); rx = 1'b1;
    idle(40);
    chk("s2_rdy", 32'(cmd_rdy), 32'h0);
    chk("s2_cmd", 32'(cmd), 32'hA5);
    chk("s2_no_frm", 32'(fast_frm), 32'hFFFF_FFFF);
    $display("txn s2: glitch, cmd=%h rdy=%b", cmd, cmd_rdy);

    // 0x3C with low stop bit: frm_err at the stop sample edge s + 154
    send_frame(1'b0, 8'h3C, D, 1'b0, 10, 1'b0, s);
    @(negedge clk); rx = 1'b1;
    idle(20);
    chk("s3_frm_edge", 32'(fast_frm), 32'(s + 154));
    chk("s3_rdy", 32'(cmd_rdy), 32'h0);
    chk("s3_cmd", 32'(cmd), 32'hA5);
    send_frame(1'b0, 8'h81, D, 1'b1, 10, 1'b0, s);
    idle(2);
    chk("s3_cmd81", 32'(cmd), 32'h81);
    chk("s3_rdy81", 32'(cmd_rdy), 32'h1);
    $display("txn s3: framing error then 81, cmd=%h", cmd);
    pulse_clr();

    // back-to-back 0x11, 0x22 (overrun), 0x33 with clear in its load cycle
    ovr_cnt = 0;
    send_frame(1'b0, 8'h11, D, 1'b1, 10, 1'b0, s);
    send_frame(1'b0, 8'h22, D, 1'b1, 10, 1'b0, s);
    chk("s4_cmd22", 32'(cmd), 32'h22);
    send_frame(1'b0, 8'h33, D, 1'b1, 10, 1'b1, s);
    idle(2);
    chk("s4_cmd33", 32'(cmd), 32'h33);
    chk("s4_rdy33", 32'(cmd_rdy), 32'h1);
    chk("s4_ovr_count", 32'(ovr_cnt), 32'd1);
    $display("txn s4: 11/22/33, cmd=%h ovr_pulses=%0d", cmd, ovr_cnt);

    // reset after start + 4 data bits of 0xFF
    send_frame(1'b0, 8'hFF, D, 1'b1, 5, 1'b0, s);
    @(negedge clk); rst_n = 1'b0;
    #1;
    chk("s5_reset_cmd", 32'(cmd), 32'h00);
    chk("s5_reset_rdy", 32'(cmd_rdy), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(5);
    send_frame(1'b0, 8'h5A, D, 1'b1, 10, 1'b0, s);
    idle(2);
    chk("s5_cmd5a", 32'(cmd), 32'h5A);
    chk("s5_rdy5a", 32'(cmd_rdy), 32'h1);
    $display("txn s5: reset mid-byte then 5A, cmd=%h", cmd);
    pulse_clr();

    // BAUD_DIV=2604, 0x47 at +2% then -2% bit time; latency s + 3 + 1302 + 9*2604 = s + 24741
    send_frame(1'b1, 8'h47, 2656, 1'b1, 10, 1'b0, s);
    idle(10);
    chk("s6_fast_cmd", 32'(cmd_s), 32'h47);
    chk("s6_fast_rdy", 32'(cmd_rdy_s), 32'h1);
    chk("s6_fast_latency", 32'(slow_rise), 32'(s + 24741));
    $display("txn s6a: 47 at +2%%, cmd=%h", cmd_s);
    @(negedge clk); clr_slow = 1'b1;
    @(negedge clk); clr_slow = 1'b0;
    chk("s6_clr", 32'(cmd_rdy_s), 32'h0);
    send_frame(1'b1, 8'h47, 2552, 1'b1, 10, 1'b0, s);
    idle(10);
    chk("s6_slow_cmd", 32'(cmd_s), 32'h47);
    chk("s6_slow_rdy", 32'(cmd_rdy_s), 32'h1);
    chk("s6_slow_latency", 32'(slow_rise), 32'(s + 24741));
    chk("s6_no_err", 32'(slow_bad), 32'h0);
    $display("txn s6b: 47 at -2%%, cmd=%h", cmd_s);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
